// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared definitions for the byte-stream program loader:
//               FSM state encoding, frame field widths and the default
//               frame start byte.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

  // Frame field widths
  localparam int LEN_W  = 16;
  localparam int CSUM_W = 8;
  // Word counter carries one extra bit so it can hold a full 16-bit length.
  localparam int CNT_W  = LEN_W + 1;

  // Default frame start byte
  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  // Loader FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LEN0  = 3'd1;
  localparam state_t ST_LEN1  = 3'd2;
  localparam state_t ST_DATA  = 3'd3;
  localparam state_t ST_WRITE = 3'd4;
  localparam state_t ST_CSUM  = 3'd5;
  localparam state_t ST_DONE  = 3'd6;
  localparam state_t ST_ERROR = 3'd7;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : loader_word_assembler
// Description : Packs payload bytes little-endian into a 32-bit word, flags
//               the byte that completes a word and keeps the running 8-bit
//               payload checksum.
// Ports       : clk, reset_ni    - clock, synchronous active-low reset
//               clear_i          - frame restart: zero byte index and checksum
//               byte_valid_i     - a payload byte is accepted this cycle
//               byte_i           - payload byte
//               word_o           - assembled word (drives memory write data)
//               word_done_o      - this accepted byte is lane 3 of a word
//               csum_o           - modulo-256 sum of payload bytes so far
// Revision    : 1.0 - initial release
// ============================================================================
module loader_word_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_ni,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic [31:0]       word_o,
  output logic              word_done_o,
  output logic [CSUM_W-1:0] csum_o
);

  logic [1:0]        idx_q,  idx_d;
  logic [31:0]       word_q, word_d;
  logic [CSUM_W-1:0] csum_q, csum_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    csum_d = csum_q;
    if (clear_i) begin
      idx_d  = 2'd0;
      csum_d = '0;
    end else if (byte_valid_i) begin
      word_d[8*idx_q +: 8] = byte_i;
      idx_d                = idx_q + 2'd1;   // wraps 3 -> 0 for the next word
      csum_d               = csum_q + byte_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      idx_q  <= 2'd0;
      word_q <= 32'd0;
      csum_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
      csum_q <= csum_d;
    end
  end

  assign word_o      = word_q;
  assign word_done_o = byte_valid_i && !clear_i && (idx_q == 2'd3);
  assign csum_o      = csum_q;

endmodule : loader_word_assembler
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Boot loader that parses a framed byte stream
//               (MAGIC, len[7:0], len[15:8], payload, checksum) and writes the
//               payload as little-endian 32-bit words into program memory,
//               holding the CPU until a valid image has been loaded.
// Ports       : clk, reset           - clock, synchronous active-low reset
//               rx_data/rx_valid/rx_ready - incoming byte stream handshake
//               address, wen, ren, data_in, byte_select_vector - memory port
//               cpu_hold             - CPU stall while a frame is in flight
//               done / error         - sticky load status
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned WORD_COUNT_MAX = 8192,
  parameter int unsigned BASE_WORD      = 0,
  parameter logic [7:0]  MAGIC          = MAGIC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [29:0] address,
  output logic        wen,
  output logic        ren,
  output logic [31:0] data_in,
  output logic [3:0]  byte_select_vector,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam logic [29:0]      c_base = 30'(BASE_WORD);
  localparam logic [CNT_W-1:0] c_max  = CNT_W'(WORD_COUNT_MAX);

  // Address wrap must be unreachable and the limit must fit the length field.
  if ((64'(BASE_WORD) + 64'(WORD_COUNT_MAX) > 64'h4000_0000) ||
      (WORD_COUNT_MAX > 32'd65535)) begin : g_param_check
    $error("program_loader: illegal WORD_COUNT_MAX/BASE_WORD combination");
  end

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q,   len_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [29:0]      addr_q,  addr_d;
  logic             hold_q,  hold_d;
  logic             done_q,  done_d;
  logic             err_q,   err_d;

  logic              w_xfer;
  logic              w_restart;
  logic              w_word_done;
  logic [31:0]       w_word;
  logic [CSUM_W-1:0] w_csum;
  logic [LEN_W-1:0]  w_len_full;
  logic [CNT_W-1:0]  w_cnt_next;

  assign w_xfer     = rx_valid && rx_ready;
  // MAGIC only opens a frame from the resting states; inside a frame it is data.
  assign w_restart  = w_xfer && (rx_data == MAGIC) &&
                      ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                       (state_q == ST_ERROR));
  assign w_len_full = {rx_data, len_q[7:0]};
  assign w_cnt_next = cnt_q + 1'b1;

  loader_word_assembler u_asm (
    .clk          (clk),
    .reset_ni     (reset),
    .clear_i      (w_restart),
    .byte_valid_i (w_xfer && (state_q == ST_DATA)),
    .byte_i       (rx_data),
    .word_o       (w_word),
    .word_done_o  (w_word_done),
    .csum_o       (w_csum)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (w_restart) begin
          state_d = ST_LEN0;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_LEN0: begin
        if (w_xfer) begin
          len_d[7:0] = rx_data;
          state_d    = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (w_xfer) begin
          len_d  = w_len_full;
          cnt_d  = '0;
          addr_d = c_base;
          if ({1'b0, w_len_full} > c_max) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else if (w_len_full == '0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_word_done) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        addr_d  = addr_q + 30'd1;
        cnt_d   = w_cnt_next;
        state_d = (w_cnt_next == {1'b0, len_q}) ? ST_CSUM : ST_DATA;
      end
      ST_CSUM: begin
        if (w_xfer) begin
          if (rx_data == w_csum) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= c_base;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // WRITE is the only back-pressure cycle and also the single write-strobe cycle.
  assign rx_ready           = (state_q != ST_WRITE);
  assign wen                = (state_q == ST_WRITE);
  assign ren                = 1'b0;
  assign address            = addr_q;
  assign data_in            = w_word;
  assign byte_select_vector = wen ? 4'b1111 : 4'b0000;
  assign cpu_hold           = hold_q;
  assign done               = done_q;
  assign error              = err_q;

endmodule : program_loader
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader. Frames are built in
//               the bench; expected memory writes and final status come from
//               the frame contents (words at BASE_WORD+i, checksum = byte sum
//               mod 256).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  localparam logic [7:0] MAGIC = 8'hA5;
  localparam int         WMAX  = 8192;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [29:0] address;
  logic        wen;
  logic        ren;
  logic [31:0] data_in;
  logic [3:0]  byte_select_vector;
  logic        cpu_hold;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  program_loader #(
    .WORD_COUNT_MAX (WMAX),
    .BASE_WORD      (0),
    .MAGIC          (MAGIC)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .rx_data            (rx_data),
    .rx_valid           (rx_valid),
    .rx_ready           (rx_ready),
    .address            (address),
    .wen                (wen),
    .ren                (ren),
    .data_in            (data_in),
    .byte_select_vector (byte_select_vector),
    .cpu_hold           (cpu_hold),
    .done               (done),
    .error              (error)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [29:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] plan[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor plus per-cycle handshake/strobe rules.
  always @(negedge clk) begin
    check_eq("ready_is_not_wen", {31'd0, rx_ready}, {31'd0, ~wen});
    check_eq("byte_select", {28'd0, byte_select_vector}, wen ? 32'hF : 32'h0);
    check_eq("ren_zero", {31'd0, ren}, 32'd0);
    if (wen) begin
      wr_addr.push_back(address);
      wr_data.push_back(data_in);
    end
  end

  task automatic drive_byte(input logic [7:0] b, input bit gaps);
    int tries;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    tries    = 0;
    forever begin
      #1;
      if (rx_ready) begin
        @(negedge clk);
        break;
      end
      tries++;
      if (tries > 3) begin
        check_eq("ready_timeout", {31'd0, rx_ready}, 32'd1);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_writes(input string tag, input int n_exp);
    check_eq({tag, "_wr_count"}, wr_addr.size(), n_exp);
    for (int i = 0; i < n_exp && i < wr_addr.size(); i++) begin
      check_eq({tag, "_wr_addr"}, {2'b00, wr_addr[i]}, i);
      check_eq({tag, "_wr_data"}, wr_data[i], plan[i]);
    end
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Sends one frame carrying the words in plan[]; oversize sends len=WMAX+1
  // and nothing after it.
  task automatic run_frame(input string tag, input bit bad_csum, input bit gaps,
                           input int npre, input bit oversize);
    logic [7:0]  b;
    logic [7:0]  sum;
    logic [15:0] len;
    logic [31:0] w;
    int          t0;
    bit          ok;
    @(negedge clk);
    sum = 8'd0;
    for (int i = 0; i < npre; i++) begin
      b = 8'($urandom);
      if (b == MAGIC) b = 8'h00;
      drive_byte(b, gaps);
    end
    t0 = cyc;
    drive_byte(MAGIC, gaps);
    check_eq({tag, "_hold_on_magic"}, {31'd0, cpu_hold}, 32'd1);
    check_eq({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_err_clr"}, {31'd0, error}, 32'd0);
    len = oversize ? 16'(WMAX + 1) : 16'(plan.size());
    drive_byte(len[7:0], gaps);
    drive_byte(len[15:8], gaps);
    if (!oversize) begin
      for (int i = 0; i < plan.size(); i++) begin
        w = plan[i];
        for (int k = 0; k < 4; k++) begin
          b   = w[8*k +: 8];
          sum = sum + b;
          drive_byte(b, gaps);
        end
      end
      drive_byte(bad_csum ? sum + 8'd1 : sum, gaps);
      if (!gaps)
        check_eq({tag, "_frame_cycles"}, cyc - t0, 4 + 5 * plan.size());
    end
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    ok = !oversize && !bad_csum;
    check_eq({tag, "_done"}, {31'd0, done}, {31'd0, ok});
    check_eq({tag, "_error"}, {31'd0, error}, {31'd0, !ok});
    check_eq({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, !ok});
    check_writes(tag, oversize ? 0 : plan.size());
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ready"}, {31'd0, rx_ready}, 32'd1);
    check_eq({tag, "_wen"}, {31'd0, wen}, 32'd0);
    check_eq({tag, "_addr"}, {2'b00, address}, 32'd0);
    check_eq({tag, "_data"}, data_in, 32'd0);
    check_eq({tag, "_bsv"}, {28'd0, byte_select_vector}, 32'd0);
    check_eq({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sum;
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    #2;
    check_reset_state("reset");
    reset = 1'b1;

    // Basic two-word load, continuous valid.
    plan = {32'h12345678, 32'hDEADBEEF};
    sum  = 8'h78 + 8'h56 + 8'h34 + 8'h12 + 8'hEF + 8'hBE + 8'hAD + 8'hDE;
    check_eq("basic_csum_model", {24'd0, sum}, 32'h4C);
    run_frame("basic", 1'b0, 1'b0, 0, 1'b0);

    // Bad checksum, then a good frame clears error.
    run_frame("badcsum", 1'b1, 1'b0, 0, 1'b0);
    run_frame("recover", 1'b0, 1'b0, 0, 1'b0);

    // Oversize length: no writes at all.
    plan = {};
    run_frame("oversize", 1'b0, 1'b0, 0, 1'b1);

    // Zero length with a garbage prefix.
    plan = {};
    run_frame("zero_len", 1'b0, 1'b0, 2, 1'b0);

    // Mid-frame reset after 6 payload bytes.
    plan = {32'hCAFEF00D, 32'h0BADBEEF};
    @(negedge clk);
    drive_byte(MAGIC, 1'b0);
    drive_byte(8'h02, 1'b0);
    drive_byte(8'h00, 1'b0);
    for (int k = 0; k < 6; k++) begin
      logic [63:0] pay;
      pay = {plan[1], plan[0]};
      drive_byte(pay[8*k +: 8], 1'b0);
    end
    rx_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #2;
    check_reset_state("midreset");
    repeat (6) @(negedge clk);
    #2;
    check_writes("midreset", 1);
    plan = {32'h01020304, 32'hA5A5A5A5, 32'hFFFFFFFF};
    run_frame("after_reset", 1'b0, 1'b0, 0, 1'b0);

    // Randomized frames with random rx_valid gaps and payload.
    for (int f = 0; f < 20; f++) begin
      plan = {};
      repeat ($urandom_range(0, 6)) plan.push_back($urandom);
      run_frame("random", ($urandom_range(0, 3) == 0), 1'b1,
                $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_program_loader
`default_nettype wire
